// File: rtl/rr_mux_arbiter_if.sv
// Handshake bundle between the request channels, the arbiter and its consumer.
// The master side drives the requests and the consumer ready; the slave side is the arbiter.
interface rr_mux_arbiter_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
);
  logic                    sel_mode;
  logic [SEL_W-1:0]        sel;
  logic [NUM_IN*WIDTH-1:0] in_data;
  logic [NUM_IN-1:0]       in_valid;
  logic [NUM_IN-1:0]       in_ready;
  logic [WIDTH-1:0]        out_data;
  logic [SEL_W-1:0]        out_src;
  logic                    out_valid;
  logic                    out_ready;

  modport master (
    output sel_mode, sel, in_data, in_valid, out_ready,
    input  in_ready, out_data, out_src, out_valid
  );

  modport slave (
    input  sel_mode, sel, in_data, in_valid, out_ready,
    output in_ready, out_data, out_src, out_valid
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// NUM_IN-way selector with a one-word registered output stage, picking a channel
// either by explicit index or by fair round-robin, with valid/ready on every port.
module rr_mux_arbiter #(
  parameter int WIDTH  = 32,
  parameter int NUM_IN = 8,
  parameter int SEL_W  = $clog2(NUM_IN)
) (
  input logic             clock,
  input logic             reset,
  rr_mux_arbiter_if.slave bus
);

  logic [SEL_W-1:0]  ptr;
  logic [SEL_W-1:0]  ptr_next;
  logic [SEL_W-1:0]  grant_idx;
  logic              grant_any;
  logic              load;
  logic [NUM_IN-1:0] ready_vec;
  logic [WIDTH-1:0]  grant_data;

  logic              out_valid_q;
  logic [WIDTH-1:0]  out_data_q;
  logic [SEL_W-1:0]  out_src_q;

  // The output register can take a new word when it is empty or being drained now.
  assign load = !out_valid_q || bus.out_ready;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
    grant_any = 1'b0;
    grant_idx = '0;
    if (bus.sel_mode) begin
      // An out-of-range sel matches no channel, so it simply yields no grant.
      for (int i = 0; i < NUM_IN; i++) begin
        if (bus.sel == SEL_W'(i) && bus.in_valid[i]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'(i);
        end
      end
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!grant_any && bus.in_valid[(int'(ptr) + k) % NUM_IN]) begin
          grant_any = 1'b1;
          grant_idx = SEL_W'((int'(ptr) + k) % NUM_IN);
        end
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (load && grant_any && !reset) begin
      ready_vec[grant_idx] = 1'b1;
    end
  end

  assign grant_data = bus.in_data[int'(grant_idx)*WIDTH +: WIDTH];
  assign ptr_next   = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clock) begin
    // NOTE: registered state uses non-blocking assignments so every flop samples pre-edge values.
    if (reset) begin
      // NOTE: data and source are reset too, because their zero value is observable after reset.
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_src_q   <= '0;
      ptr         <= '0;
    end else if (load) begin
      if (grant_any) begin
        out_valid_q <= 1'b1;
        out_data_q  <= grant_data;
        out_src_q   <= grant_idx;
        if (!bus.sel_mode) begin
          ptr <= ptr_next;
        end
      end else begin
        out_valid_q <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_src   = out_src_q;

endmodule
